// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// common to the transmit and receive channels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP_1 = 3'b011,
    STOP_2 = 3'b100
  } uart_state_e;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam int   STOP_BITS   = 2;

  // 100 MHz system clock at 115200 baud
  localparam int   DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: modulo-CLKS_PER_BIT counter with synchronous clear.
// tick marks the last cycle of each bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, two stop bits.
// Byte accepted with a valid/ready handshake only while idle.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e          state;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 clear;

  // Counter is held at zero while idle, so it is already cleared on the
  // handshake edge and the start bit gets a full period.
  assign clear = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  // TX is registered from the current state, so the line changes one edge
  // after the state does and never sees combinational decode glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      TX       <= STOP_LEVEL;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          TX <= STOP_LEVEL;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            state    <= START;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          TX <= START_LEVEL;
          if (tick) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          TX <= shreg[0];
          if (tick) begin
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP_1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        STOP_1: begin
          TX <= STOP_LEVEL;
          if (tick) begin
            state <= STOP_2;
          end
        end
        STOP_2: begin
          TX <= STOP_LEVEL;
          if (tick) begin
            state    <= IDLE;
            done     <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          TX       <= STOP_LEVEL;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLKS_PER_BIT=4, DATA_BITS=8.
module tb_uart_tx_frame;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int FRAME = (3 + DB) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_ready;
  logic          TX;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [7:0] lb_bytes [4] = '{8'h00, 8'h55, 8'h80, 8'hFF};

  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TX      (TX),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status vector {TX, busy, tx_ready, done}; idle is 4'b1010.
  function automatic logic [7:0] status();
    return {4'b0000, TX, busy, tx_ready, done};
  endfunction

  // Caller has tx_valid/tx_data set; the next edge is the handshake edge.
  task automatic run_frame(input logic [7:0] b, input logic keep_valid,
                           input logic [7:0] next_data, input int pulse_k);
    logic [7:0] rx;
    logic       exp_tx;
    int         idx;
    rx = '0;
    step();
    if (!keep_valid) tx_valid = 1'b0;
    tx_data = next_data;
    chk("accept", 0, status(), 8'b0000_1100);
    for (int k = 1; k <= FRAME; k++) begin
      if (pulse_k > 0 && k == pulse_k) begin
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
      end
      if (pulse_k > 0 && k == pulse_k + 2) tx_valid = 1'b0;
      step();
      idx = (k - 1) / CPB;
      if (idx == 0)       exp_tx = 1'b0;
      else if (idx <= DB) exp_tx = b[idx-1];
      else                exp_tx = 1'b1;
      if (((k - 1) % CPB) == 1 && idx >= 1 && idx <= DB) rx[idx-1] = TX;
      chk("frame", k, status(),
          {4'b0000, exp_tx, 1'(k < FRAME), 1'(k == FRAME), 1'(k == FRAME)});
    end
    chk("rx_byte", int'(b), rx, b);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) step();
    chk("reset", 0, status(), 8'h0A);
    rst = 1'b1;
    step();
    chk("idle", 0, status(), 8'h0A);

    // Single 0xA5 frame
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    run_frame(8'hA5, 1'b0, 8'h00, 0);
    step();
    chk("post_a5", 0, status(), 8'h0A);

    // Valid held: 0x00 then 0xFF back to back, handshake on the done cycle
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    run_frame(8'h00, 1'b1, 8'hFF, 0);
    run_frame(8'hFF, 1'b0, 8'h00, 0);
    step();
    chk("post_ff", 0, status(), 8'h0A);

    // Valid pulsed mid-frame with another byte is ignored
    tx_valid = 1'b1;
    tx_data  = 8'h3A;
    run_frame(8'h3A, 1'b0, 8'h3A, 10);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("no_second", i, status(), 8'h0A);
    end

    // Reset during DATA abandons the frame
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    step();
    tx_valid = 1'b0;
    repeat (10) step();
    chk("in_data", 0, status(), 8'b0000_0100);
    rst = 1'b0;
    step();
    chk("rst_mid", 0, status(), 8'h0A);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("after_rst", i, status(), 8'h0A);
    end

    // Fresh byte after the abandoned frame
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    run_frame(8'h3C, 1'b0, 8'h3C, 0);

    // Loopback-style recovery of a byte sequence
    for (int j = 0; j < 4; j++) begin
      step();
      tx_valid = 1'b1;
      tx_data  = lb_bytes[j];
      run_frame(lb_bytes[j], 1'b0, lb_bytes[j], 0);
    end
    step();
    chk("final_idle", 0, status(), 8'h0A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit channel; the stage directly upstream of the receive FSM.
- Accepts a byte via a valid/ready handshake and serialises it on TX.
- Frame: 1 start bit (0), DATA_BITS data bits LSB first, 2 stop bits (1). This matches the receiver's IDLE/START/DATA/STOP_1/STOP_2 framing.
- Owns its own bit-period timing, so it is self-contained on the sending side.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (rst==0 resets at next rising clk edge).
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- TX  output  1  serial line; idles high.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset values (state IDLE): TX=1, tx_ready=1, busy=0, done=0, bit counter=0, baud counter=0, shift register=0.
- Handshake: a transfer occurs on the edge where tx_valid && tx_ready. On that edge:
  - tx_data is latched into the shift register.
  - State goes to START and the baud counter clears.
  - tx_data is ignored at all other times.
- tx_valid may stay high. A new byte is accepted only after the block returns to IDLE.
- All outputs are registered. TX must be glitch-free.
- States and transitions; a "bit tick" is baud counter == CLKS_PER_BIT-1, after which the counter wraps to 0:
  - IDLE: TX=1. Moves to START on handshake.
  - START: TX=0. On bit tick, moves to DATA with bit counter=0.
  - DATA: TX = shift register[0]. On bit tick, shift right by 1 and increment the bit counter. When the bit counter == DATA_BITS-1 at the tick, move to STOP_1.
  - STOP_1: TX=1. On bit tick, moves to STOP_2.
  - STOP_2: TX=1. On bit tick, moves to IDLE with done=1 for exactly that one cycle.
  - Unused encodings: move to IDLE.
- Timing:
  - TX falls on the first edge after the handshake edge.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Frame length is (3+DATA_BITS)*CLKS_PER_BIT cycles; 11*CLKS_PER_BIT for the defaults.
  - tx_ready rises on the same edge that done rises, so the minimum frame-to-frame gap is 1 clk of TX=1 idle.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits. Bit counter is $clog2(DATA_BITS) bits, minimum 1 bit. No overflow is possible under the legal ranges.
- Reset mid-frame: on the next edge the block goes to IDLE and TX=1. No done pulse. The partial frame is abandoned; the receiver resynchronises on the next start bit.
- tx_valid deasserted in any non-IDLE state has no effect on the frame in progress.

Decomposition:
- uart_pkg (shared with the receive side):
  - State encoding constants IDLE=3'b000, START=3'b001, DATA=3'b010, STOP_1=3'b011, STOP_2=3'b100.
  - Frame constants: start level 0, stop level 1, stop bit count 2.
  - Default CLKS_PER_BIT.
- One sub-module: uart_baud_tick. It is a CLKS_PER_BIT modulo counter with a synchronous clear and a tick output. The receiver side reuses it for midbit generation.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Send 0xA5 after reset:
  - TX sequence, each level for 4 clk: 0 | 1,0,1,0,0,1,0,1 | 1,1.
  - done pulses for one cycle 44 clk after the handshake edge.
  - busy is high for those 44 cycles.
- tx_valid held high with 0x00 then 0xFF:
  - Second handshake occurs exactly when done is high.
  - One idle-high cycle separates the frames.
  - 0xFF frame shows only the start bit low.
- tx_valid pulsed mid-frame with a different byte: ignored, tx_ready=0, the frame in progress is unchanged, and there is no second frame.
- rst=0 asserted during the DATA state:
  - Next edge: TX=1, tx_ready=1, busy=0, and done never pulses.
  - A subsequent byte 0x3C transmits correctly.
- Loopback: TX wired to the receive channel; send 0x00, 0x55, 0x80, 0xFF. The receiver's done and data match each byte in order.
